// File: rtl/weight_encode_loader.sv
// Column weight loader: collects SIZE signed weights, encodes each into the 5-bit
// RPE code, and streams them down the column as one gap-free burst.
module weight_encode_loader #(
  parameter int SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] w_in,
  input  logic       w_in_valid,
  output logic       w_in_ready,
  input  logic       array_busy,
  input  logic [7:0] act_in,
  output logic [6:0] act_out,
  output logic [4:0] Weight_out,
  output logic       Weight_out_valid,
  output logic       busy,
  output logic       load_done
);

  // state   | meaning
  // IDLE    | empty, waiting for the first weight of a load
  // COLLECT | accepting weights 1..SIZE-1 into the buffer
  // WAIT    | buffer full, holding until the column stops computing
  // SHIFT   | emitting one code per cycle, buf[SIZE-1] first
  // DONE    | burst finished, pulse load_done and return to IDLE

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  idx;
  logic [4:0]     wbuf [SIZE];
  logic           accept;
  logic           unused_act_lsb;

  // Odd weights within +-15 are exact (MSR4); everything else is rounded to a
  // multiple of 16 and clamped so the magnitude fits the 4-bit field.
  function automatic logic [4:0] encode_weight(input logic signed [7:0] w);
    logic signed [4:0] q;
    if (w[0] && (w >= -8'sd15) && (w <= 8'sd15)) begin
      encode_weight = {1'b0, w[4:1]};
    end else begin
      q = 5'(($signed({w[7], w}) + 9'sd8) >>> 4);
      if (q > 5'sd7)
        q = 5'sd7;
      else if (q < -5'sd7)
        q = -5'sd7;
      if (q[4])
        q = q - 5'sd1;
      encode_weight = {1'b1, q[3:0]};
    end
  endfunction

  assign accept = w_in_valid & w_in_ready;

  // The RPE re-inserts the dropped LSB as 1, so only the top seven bits travel.
  assign act_out        = act_in[7:1];
  assign unused_act_lsb = act_in[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      count            <= '0;
      idx              <= '0;
      w_in_ready       <= 1'b1;
      Weight_out       <= '0;
      Weight_out_valid <= 1'b0;
      busy             <= 1'b0;
      load_done        <= 1'b0;
      for (int i = 0; i < SIZE; i++) wbuf[i] <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wbuf[0] <= encode_weight($signed(w_in));
            count   <= CW'(1);
            state   <= COLLECT;
            busy    <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            wbuf[count] <= encode_weight($signed(w_in));
            count       <= count + 1'b1;
            if (count == CW'(SIZE - 1)) begin
              state      <= WAIT;
              w_in_ready <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!array_busy) begin
            state <= SHIFT;
            idx   <= CW'(SIZE - 1);
          end
        end
        SHIFT: begin
          // No stall path here: a gap would shift every code one RPE too far.
          Weight_out       <= wbuf[idx];
          Weight_out_valid <= 1'b1;
          idx              <= idx - 1'b1;
          if (idx == '0)
            state <= DONE;
        end
        DONE: begin
          Weight_out_valid <= 1'b0;
          load_done        <= 1'b1;
          count            <= '0;
          w_in_ready       <= 1'b1;
          busy             <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          state      <= IDLE;
          w_in_ready <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_encode_loader.sv
// Bench for weight_encode_loader: directed and random loads compared against an
// arithmetic encoding model and an 8-deep column shift model.
module tb_weight_encode_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] w_in;
  logic       w_in_valid;
  logic       w_in_ready;
  logic       array_busy;
  logic [7:0] act_in;
  logic [6:0] act_out;
  logic [4:0] Weight_out;
  logic       Weight_out_valid;
  logic       busy;
  logic       load_done;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  logic [7:0] ws [8];
  logic [7:0] nxt_w;
  logic [4:0] pe [8];

  weight_encode_loader #(.SIZE(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .w_in             (w_in),
    .w_in_valid       (w_in_valid),
    .w_in_ready       (w_in_ready),
    .array_busy       (array_busy),
    .act_in           (act_in),
    .act_out          (act_out),
    .Weight_out       (Weight_out),
    .Weight_out_valid (Weight_out_valid),
    .busy             (busy),
    .load_done        (load_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && w_in_valid && w_in_ready) acc_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoding from the arithmetic rules: exact odd weights, else round to /16 and clamp.
  function automatic logic [4:0] ref_enc(input int w);
    int n, q, v;
    if ((w % 2 != 0) && w >= -15 && w <= 15) begin
      v = (w - 1) / 2;
      return 5'(v & 15);
    end
    n = w + 8;
    q = (n >= 0) ? n / 16 : -((-n + 15) / 16);
    if (q > 7) q = 7;
    if (q < -7) q = -7;
    v = (q >= 0) ? q : q - 1;
    return 5'(16 + (v & 15));
  endfunction

  function automatic logic [6:0] ref_act(input int a);
    int h;
    h = (a >= 0) ? a / 2 : -((-a + 1) / 2);
    return 7'(h & 127);
  endfunction

  task automatic rand_ws();
    for (int i = 0; i < 8; i++) ws[i] = 8'($urandom_range(0, 255));
  endtask

  // Feeds ws[first..7], waits out array_busy, captures the burst into the column model.
  task automatic run_load(input int first, input int busy_cycles, input bit hold_valid,
                          input int rst_beat);
    int acc0;
    acc0 = acc_cnt;
    array_busy = (busy_cycles > 0);
    for (int i = first; i < 8; i++) begin
      w_in = ws[i];
      w_in_valid = 1'b1;
      chk("ready_collect", 32'(w_in_ready), 32'd1);
      tick();
    end
    if (hold_valid) w_in = nxt_w;
    else w_in_valid = 1'b0;
    chk("accepts_collected", 32'(acc_cnt - acc0), 32'(8 - first));
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_ready", 32'(w_in_ready), 32'd0);
    for (int c = 0; c < busy_cycles; c++) begin
      tick();
      chk("wait_hold_valid", 32'(Weight_out_valid), 32'd0);
      chk("wait_hold_ready", 32'(w_in_ready), 32'd0);
    end
    array_busy = 1'b0;
    tick();
    chk("shift_entry_valid", 32'(Weight_out_valid), 32'd0);
    tick();
    for (int b = 0; b < 8; b++) begin
      chk("beat_valid", 32'(Weight_out_valid), 32'd1);
      chk("beat_ready", 32'(w_in_ready), 32'd0);
      chk("beat_order", 32'(Weight_out), 32'(ref_enc(int'($signed(ws[7 - b])))));
      for (int k = 7; k > 0; k--) pe[k] = pe[k - 1];
      pe[0] = Weight_out;
      if (b == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(Weight_out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(w_in_ready), 32'd1);
        chk("rst_wout", 32'(Weight_out), 32'd0);
        w_in_valid = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        return;
      end
      tick();
    end
    chk("post_valid", 32'(Weight_out_valid), 32'd0);
    chk("load_done_pulse", 32'(load_done), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    if (hold_valid) begin
      chk("bp_ready_back", 32'(w_in_ready), 32'd1);
      chk("bp_no_extra", 32'(acc_cnt - acc0), 32'(8 - first));
      tick();
      chk("bp_ninth", 32'(acc_cnt - acc0), 32'(9 - first));
      w_in_valid = 1'b0;
    end else begin
      tick();
      chk("load_done_clear", 32'(load_done), 32'd0);
      chk("idle_ready", 32'(w_in_ready), 32'd1);
    end
    for (int k = 0; k < 8; k++)
      chk("column_pe", 32'(pe[k]), 32'(ref_enc(int'($signed(ws[k])))));
  endtask

  initial begin
    logic [4:0] tbl_a [8];
    logic [7:0] acts [5];
    logic [6:0] act_exp [5];
    int a;

    rst = 1'b1; w_in = '0; w_in_valid = 1'b0; array_busy = 1'b0; act_in = '0;
    tick();
    tick();
    chk("reset_ready", 32'(w_in_ready), 32'd1);
    chk("reset_valid", 32'(Weight_out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    chk("reset_wout", 32'(Weight_out), 32'd0);
    act_in = 8'h06;
    #1;
    chk("act_in_reset", 32'(act_out), 32'h03);
    rst = 1'b0;
    tick();

    acts    = '{8'h80, 8'hFF, 8'h00, 8'h06, 8'h7F};
    act_exp = '{7'b1000000, 7'b1111111, 7'b0000000, 7'b0000011, 7'b0111111};
    for (int i = 0; i < 5; i++) begin
      act_in = acts[i];
      #1;
      chk("act_table", 32'(act_out), 32'(act_exp[i]));
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 255) - 128;
      act_in = 8'(a);
      #1;
      chk("act_random", 32'(act_out), 32'(ref_act(a)));
    end

    // Encode table: 5,-3,15,-15,17,-16,0,127 then -128.
    ws = '{8'd5, 8'hFD, 8'd15, 8'hF1, 8'd17, 8'hF0, 8'd0, 8'd127};
    tbl_a = '{5'b00010, 5'b01110, 5'b00111, 5'b01000, 5'b10001, 5'b11110, 5'b10000, 5'b10111};
    run_load(0, 0, 1'b0, -1);
    for (int k = 0; k < 8; k++) chk("encode_table", 32'(pe[k]), 32'(tbl_a[k]));

    rand_ws();
    ws[0] = 8'h80;
    run_load(0, 0, 1'b0, -1);
    chk("encode_m128", 32'(pe[0]), 32'b11000);

    ws = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd13, 8'd15};
    run_load(0, 0, 1'b0, -1);
    for (int k = 0; k < 8; k++) chk("odd_ramp", 32'(pe[k]), 32'(k));

    rand_ws();
    run_load(0, 20, 1'b0, -1);

    rand_ws();
    nxt_w = 8'($urandom_range(0, 255));
    run_load(0, 0, 1'b1, -1);

    rand_ws();
    ws[0] = nxt_w;
    run_load(1, 0, 1'b0, 3);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);

    for (int r = 0; r < 4; r++) begin
      rand_ws();
      run_load(0, $urandom_range(0, 4), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
